// File: rtl/acl2_sampler_if.sv
// Request/finished handshake between the ADXL362 polling sequencer and the SPI register-transaction controller.
interface acl2_sampler_if;
  logic        ctl_req;
  logic        ctl_read;
  logic [7:0]  ctl_addr;
  logic [7:0]  ctl_din;
  logic        ctl_finished;
  logic [11:0] ctl_dout;

  modport master (output ctl_req, ctl_read, ctl_addr, ctl_din,
                  input  ctl_finished, ctl_dout);
  modport slave  (input  ctl_req, ctl_read, ctl_addr, ctl_din,
                  output ctl_finished, ctl_dout);
endinterface

// File: rtl/acl2_sampler.sv
// ADXL362 polling sequencer: power-up configuration, then continuous averaged axis reads,
// with run-time range reprogramming and enable/park control.
module acl2_sampler #(
  parameter int unsigned N_CH     = 3,
  parameter int unsigned AVG_LOG2 = 0,
  parameter logic [2:0]  ODR      = 3'b011,
  parameter int unsigned GAP      = 0
) (
  input  logic           sclk,
  input  logic           rst,
  input  logic           enable,
  input  logic [1:0]     range_sel,
  acl2_sampler_if.master ctl,
  output logic [11:0]    acc_x,
  output logic [11:0]    acc_y,
  output logic [11:0]    acc_z,
  output logic           sample_valid,
  output logic           cfg_done
);

  localparam int unsigned AW = 12 + AVG_LOG2;
  localparam int unsigned SW = AVG_LOG2 + 1;
  localparam int unsigned GW = 16;
  localparam logic [SW-1:0] LAST_SWEEP = SW'((1 << AVG_LOG2) - 1);
  localparam logic [1:0]    LAST_CH    = 2'(N_CH - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP - 1);

  typedef enum logic [2:0] {PWR, RANGE, READ, GAP_WAIT, PARK} state_t;

  state_t                r_state;
  logic [1:0]            r_ch;
  logic [SW-1:0]         r_sweep;
  logic [GW-1:0]         r_gap;
  logic                  r_req;
  logic                  r_read;
  logic [7:0]            r_addr;
  logic [7:0]            r_din;
  logic [1:0]            r_range_q;
  logic                  r_cfg_done;
  logic                  r_valid;
  logic [11:0]           r_res [3];
  logic signed [AW-1:0]  r_acc [3];

  state_t                w_nxt;
  logic [1:0]            w_nxt_ch;
  logic                  w_clr;
  logic                  w_pub;
  logic                  w_acc_en;
  logic                  w_nxt_req;
  logic                  w_issue;
  logic                  w_fin;
  logic                  w_rng_chg;
  logic                  w_last_ch;
  logic                  w_win_done;
  logic signed [AW-1:0]  w_ext;
  logic signed [AW-1:0]  w_sum [3];

  // A completion pulse only counts while a request is outstanding.
  assign w_fin      = ctl.ctl_finished & r_req;
  assign w_rng_chg  = r_cfg_done && (range_sel != r_range_q);
  assign w_last_ch  = (r_ch == LAST_CH);
  assign w_win_done = w_last_ch && (r_sweep == LAST_SWEEP);
  assign w_ext      = AW'($signed(ctl.ctl_dout));

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_sum[i] = r_acc[i] + ((r_ch == 2'(i)) ? w_ext : '0);
    end
  end

  always_comb begin
    w_nxt    = r_state;
    w_nxt_ch = r_ch;
    w_clr    = 1'b0;
    w_pub    = 1'b0;
    w_acc_en = 1'b0;
    case (r_state)
      PWR: if (w_fin) w_nxt = RANGE;
      RANGE: if (w_fin) begin
        w_clr    = 1'b1;
        w_nxt_ch = 2'd0;
        if (w_rng_chg)   w_nxt = RANGE;
        else if (!enable) w_nxt = PARK;
        else              w_nxt = READ;
      end
      READ: if (w_fin) begin
        w_acc_en = 1'b1;
        w_pub    = w_win_done;
        w_nxt_ch = w_last_ch ? 2'd0 : r_ch + 2'd1;
        if (w_rng_chg)                     w_nxt = RANGE;
        else if (!enable)                  w_nxt = PARK;
        else if (w_win_done && (GAP != 0)) w_nxt = GAP_WAIT;
      end
      GAP_WAIT: begin
        if (w_rng_chg)             w_nxt = RANGE;
        else if (!enable)          w_nxt = PARK;
        else if (r_gap == GAP_LAST) w_nxt = READ;
      end
      PARK: begin
        if (w_rng_chg) w_nxt = RANGE;
        else if (enable) begin
          w_clr    = 1'b1;
          w_nxt_ch = 2'd0;
          w_nxt    = READ;
        end
      end
      default: w_nxt = PWR;
    endcase
  end

  // A new request is presented when entering a transaction state from idle or right after a finish.
  assign w_nxt_req = (w_nxt == PWR) || (w_nxt == RANGE) || (w_nxt == READ);
  assign w_issue   = w_nxt_req && (!r_req || w_fin);

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      r_state    <= PWR;
      r_ch       <= '0;
      r_sweep    <= '0;
      r_gap      <= '0;
      r_req      <= 1'b0;
      r_read     <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
      r_range_q  <= '0;
      r_cfg_done <= 1'b0;
      r_valid    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_res[i] <= '0;
        r_acc[i] <= '0;
      end
    end else begin
      r_state <= w_nxt;
      r_ch    <= w_nxt_ch;
      r_req   <= w_nxt_req;
      r_valid <= w_pub;
      r_gap   <= ((r_state == GAP_WAIT) && (w_nxt == GAP_WAIT)) ? r_gap + GW'(1) : '0;
      if (r_state == RANGE && w_fin) r_cfg_done <= 1'b1;
      if (w_issue) begin
        r_read <= (w_nxt == READ);
        case (w_nxt)
          PWR:     begin r_addr <= 8'h2D; r_din <= 8'h02; end
          RANGE:   begin
            r_addr    <= 8'h2C;
            r_din     <= {range_sel, 1'b0, 1'b1, 1'b0, ODR};
            r_range_q <= range_sel;
          end
          default: begin r_addr <= 8'h0E + {5'd0, w_nxt_ch, 1'b0}; r_din <= 8'h00; end
        endcase
      end
      // Publishing and restarts both empty the averaging window.
      if (w_clr || w_pub) begin
        r_sweep <= '0;
        for (int i = 0; i < 3; i++) r_acc[i] <= '0;
      end else if (w_acc_en) begin
        for (int i = 0; i < 3; i++) r_acc[i] <= w_sum[i];
        if (w_last_ch) r_sweep <= r_sweep + SW'(1);
      end
      if (w_pub) begin
        for (int i = 0; i < 3; i++) begin
          if (i < N_CH) r_res[i] <= 12'(w_sum[i] >>> AVG_LOG2);
        end
      end
    end
  end

  assign ctl.ctl_req   = r_req;
  assign ctl.ctl_read  = r_read;
  assign ctl.ctl_addr  = r_addr;
  assign ctl.ctl_din   = r_din;
  assign acc_x         = r_res[0];
  assign acc_y         = r_res[1];
  assign acc_z         = r_res[2];
  assign sample_valid  = r_valid;
  assign cfg_done      = r_cfg_done;

endmodule

// File: tb/tb_acl2_sampler.sv
// Directed bench for acl2_sampler: a 3-axis unaveraged instance and a 1-axis, 4-sweep, GAP=5 instance,
// each served by a small SPI controller model with fixed latency.
module tb_acl2_sampler;

  typedef struct packed { logic rd; logic [7:0] addr; logic [7:0] din; } txn_t;

  logic        sclk  = 1'b0;
  logic        rst_a = 1'b1, rst_b = 1'b1;
  logic        en_a  = 1'b1, en_b = 1'b1;
  logic [1:0]  rs_a  = 2'b00, rs_b = 2'b00;
  logic [11:0] ax, ay, az, bx, by, bz;
  logic        va, vb, ca, cb;
  int          errors = 0, checks = 0;

  acl2_sampler_if ifa ();
  acl2_sampler_if ifb ();

  acl2_sampler #(.N_CH(3), .AVG_LOG2(0), .ODR(3'b011), .GAP(0)) dut_a (
    .sclk(sclk), .rst(rst_a), .enable(en_a), .range_sel(rs_a), .ctl(ifa),
    .acc_x(ax), .acc_y(ay), .acc_z(az), .sample_valid(va), .cfg_done(ca));

  acl2_sampler #(.N_CH(1), .AVG_LOG2(2), .ODR(3'b011), .GAP(5)) dut_b (
    .sclk(sclk), .rst(rst_b), .enable(en_b), .range_sel(rs_b), .ctl(ifb),
    .acc_x(bx), .acc_y(by), .acc_z(bz), .sample_valid(vb), .cfg_done(cb));

  always #5 sclk = ~sclk;

  txn_t        log_a[$], log_b[$];
  txn_t        last_a;
  logic [11:0] dat_a [3];
  logic [11:0] q_b[$];
  int          lat_a = 0, lat_b = 0, n_valid_a = 0, n_reads_b = 0;
  logic        vfin_a = 1'b0, vreq_a = 1'b0;
  logic [7:0]  vaddr_a = 8'h00;
  logic [11:0] res_b[$];
  int          reads_b[$], gap_b[$];
  logic        gap_on_b = 1'b0;
  int          gap_cnt_b = 0;

  function automatic txn_t mk(input logic rd, input logic [7:0] addr, input logic [7:0] din);
    return txn_t'({rd, addr, din});
  endfunction

  // Controller model A: finishes each request three negedges after seeing it, data by register address.
  initial begin
    ifa.ctl_finished = 1'b0;
    ifa.ctl_dout     = 12'h000;
    forever begin
      @(negedge sclk);
      if (rst_a) begin
        ifa.ctl_finished = 1'b0;
        lat_a = 0;
      end else begin
        if (va && log_a.size() > 0) begin
          n_valid_a++;
          vfin_a  = ifa.ctl_finished;
          vreq_a  = ifa.ctl_req;
          last_a  = log_a[log_a.size()-1];
          vaddr_a = last_a.addr;
        end
        if (ifa.ctl_finished) begin
          ifa.ctl_finished = 1'b0;
          lat_a = 0;
        end else if (ifa.ctl_req) begin
          if (lat_a == 2) begin
            log_a.push_back(mk(ifa.ctl_read, ifa.ctl_addr, ifa.ctl_din));
            if (ifa.ctl_read) ifa.ctl_dout = dat_a[int'(ifa.ctl_addr - 8'h0E) / 2];
            else              ifa.ctl_dout = 12'h000;
            ifa.ctl_finished = 1'b1;
            lat_a = 0;
          end else lat_a++;
        end
      end
    end
  end

  // Controller model B: reads pop a sample queue; records results, read counts and idle gaps per pulse.
  initial begin
    ifb.ctl_finished = 1'b0;
    ifb.ctl_dout     = 12'h000;
    forever begin
      @(negedge sclk);
      if (rst_b) begin
        ifb.ctl_finished = 1'b0;
        lat_b = 0;
      end else begin
        if (vb) begin
          res_b.push_back(bx);
          reads_b.push_back(n_reads_b);
          gap_on_b  = 1'b1;
          gap_cnt_b = 0;
        end
        if (gap_on_b) begin
          if (!ifb.ctl_req) gap_cnt_b++;
          else begin
            gap_b.push_back(gap_cnt_b);
            gap_on_b = 1'b0;
          end
        end
        if (ifb.ctl_finished) begin
          ifb.ctl_finished = 1'b0;
          lat_b = 0;
        end else if (ifb.ctl_req) begin
          if (lat_b == 2) begin
            log_b.push_back(mk(ifb.ctl_read, ifb.ctl_addr, ifb.ctl_din));
            if (ifb.ctl_read) begin
              n_reads_b++;
              ifb.ctl_dout = (q_b.size() > 0) ? q_b.pop_front() : 12'h000;
            end else ifb.ctl_dout = 12'h000;
            ifb.ctl_finished = 1'b1;
            lat_b = 0;
          end else lat_b++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge sclk);
    #1;
  endtask

  task automatic wait_log_a(input int n, input string tag);
    int k = 0;
    while (log_a.size() < n && k < 500) begin tick(); k++; end
    chk(tag, 32'(log_a.size() >= n), 32'd1);
  endtask

  task automatic chk_txn_a(input string tag, input int i, input txn_t exp);
    txn_t obs;
    obs = (i < log_a.size()) ? log_a[i] : '1;
    chk(tag, 32'(obs), 32'(exp));
  endtask

  task automatic wait_mid_read_a(input logic any, input logic [7:0] addr, input string tag);
    int k = 0;
    while (!(ifa.ctl_req && ifa.ctl_read && !ifa.ctl_finished && (any || ifa.ctl_addr == addr))
           && k < 500) begin
      tick(); k++;
    end
    chk(tag, 32'(k < 500), 32'd1);
  endtask

  task automatic wait_valid_a(input int nv, input string tag);
    int k = 0;
    while (n_valid_a <= nv && k < 500) begin tick(); k++; end
    chk(tag, 32'(n_valid_a > nv), 32'd1);
  endtask

  initial begin
    int L, nv, hi;
    dat_a[0] = 12'h123; dat_a[1] = 12'hFED; dat_a[2] = 12'h7FF;
    q_b = '{12'd4, 12'd5, 12'd6, 12'd7, 12'hFFF, 12'hFFE, 12'hFFE, 12'hFFE};

    repeat (3) tick();
    chk("rst_req", 32'(ifa.ctl_req), 32'd0);
    chk("rst_read", 32'(ifa.ctl_read), 32'd0);
    chk("rst_addr", 32'(ifa.ctl_addr), 32'h00);
    chk("rst_din", 32'(ifa.ctl_din), 32'h00);
    chk("rst_acc", 32'({ax, ay, az}), 32'd0);
    chk("rst_valid", 32'(va), 32'd0);
    chk("rst_cfg_done", 32'(ca), 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();
    chk("first_req", 32'(ifa.ctl_req), 32'd1);
    chk("first_addr", 32'(ifa.ctl_addr), 32'h2D);

    // Configuration writes in order, outputs quiet until the range write completes.
    wait_log_a(1, "wait_pwr");
    chk_txn_a("pwr_write", 0, mk(1'b0, 8'h2D, 8'h02));
    chk("cfg_done_after_pwr", 32'(ca), 32'd0);
    wait_log_a(2, "wait_range");
    chk_txn_a("range_write", 1, mk(1'b0, 8'h2C, 8'h13));
    chk("cfg_done_pending", 32'(ca), 32'd0);
    chk("acc_pending", 32'({ax, ay, az}), 32'd0);
    tick();
    chk("cfg_done_set", 32'(ca), 32'd1);
    wait_log_a(5, "wait_reads");
    chk_txn_a("read_x", 2, mk(1'b1, 8'h0E, 8'h00));
    chk_txn_a("read_y", 3, mk(1'b1, 8'h10, 8'h00));
    chk_txn_a("read_z", 4, mk(1'b1, 8'h12, 8'h00));

    // First result one cycle after the Z finish, requests continue back to back.
    wait_valid_a(0, "wait_valid1");
    chk("valid_after_fin", 32'(vfin_a), 32'd1);
    chk("valid_after_z", 32'(vaddr_a), 32'h12);
    chk("req_held_gap0", 32'(vreq_a), 32'd1);
    chk("acc_x_1", 32'(ax), 32'h123);
    chk("acc_y_1", 32'(ay), 32'hFED);
    chk("acc_z_1", 32'(az), 32'h7FF);
    tick();
    chk("valid_one_cycle", 32'(va), 32'd0);

    // Range change during a Y read.
    wait_mid_read_a(1'b0, 8'h10, "wait_mid_y");
    rs_a = 2'b01;
    nv   = n_valid_a;
    L    = log_a.size();
    wait_log_a(L + 2, "wait_rerange");
    chk_txn_a("y_completes", L, mk(1'b1, 8'h10, 8'h00));
    chk_txn_a("rerange_write", L + 1, mk(1'b0, 8'h2C, 8'h53));
    dat_a[0] = 12'h001; dat_a[1] = 12'h002; dat_a[2] = 12'h003;
    wait_log_a(L + 3, "wait_restart");
    chk_txn_a("restart_at_x", L + 2, mk(1'b1, 8'h0E, 8'h00));
    chk("acc_x_held", 32'(ax), 32'h123);
    chk("no_pulse_on_rerange", 32'(n_valid_a), 32'(nv));
    wait_valid_a(nv, "wait_valid2");
    chk("acc_x_2", 32'(ax), 32'h001);
    chk("acc_y_2", 32'(ay), 32'h002);
    chk("acc_z_2", 32'(az), 32'h003);
    chk("cfg_done_kept", 32'(ca), 32'd1);

    // Enable dropped mid-read: transaction completes, then parked.
    wait_mid_read_a(1'b1, 8'h00, "wait_mid_any");
    en_a = 1'b0;
    L    = log_a.size();
    wait_log_a(L + 1, "wait_park_fin");
    tick();
    hi = 0;
    repeat (30) begin
      tick();
      if (ifa.ctl_req) hi++;
    end
    chk("park_req_low", 32'(hi), 32'd0);
    chk("park_no_txn", 32'(log_a.size()), 32'(L + 1));
    en_a = 1'b1;
    wait_log_a(L + 2, "wait_unpark");
    chk_txn_a("unpark_at_x", L + 1, mk(1'b1, 8'h0E, 8'h00));

    // Reset pulsed during a read.
    wait_mid_read_a(1'b1, 8'h00, "wait_mid_rst");
    rst_a = 1'b1;
    tick();
    chk("rst2_acc", 32'({ax, ay, az}), 32'd0);
    chk("rst2_cfg_done", 32'(ca), 32'd0);
    chk("rst2_req", 32'(ifa.ctl_req), 32'd0);
    chk("rst2_valid", 32'(va), 32'd0);
    log_a.delete();
    rst_a = 1'b0;
    wait_log_a(2, "wait_reconfig");
    chk_txn_a("rst2_pwr", 0, mk(1'b0, 8'h2D, 8'h02));
    chk_txn_a("rst2_range", 1, mk(1'b0, 8'h2C, 8'h53));

    // Averaging instance results recorded by its controller model.
    chk("b_pulses", 32'(res_b.size() >= 2), 32'd1);
    chk("b_gaps", 32'(gap_b.size() >= 2), 32'd1);
    if (res_b.size() >= 2 && gap_b.size() >= 2) begin
      chk("b_avg_pos", 32'(res_b[0]), 32'h005);
      chk("b_avg_neg", 32'(res_b[1]), 32'hFFE);
      chk("b_reads_1", 32'(reads_b[0]), 32'd4);
      chk("b_reads_2", 32'(reads_b[1]), 32'd8);
      chk("b_gap_1", 32'(gap_b[0]), 32'd5);
      chk("b_gap_2", 32'(gap_b[1]), 32'd5);
    end
    chk("b_unused_axes", 32'({by, bz}), 32'd0);
    chk("b_cfg_done", 32'(cb), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
